// File: rtl/shift_calib.sv
// Per-tile requantization shift calibrator: tracks tile max |x| and picks the smallest fitting shift.
// Optional SHIFT_CALIB_TRACK_EN keeps max_abs as a running maximum across tiles.
module shift_calib #(
  parameter int DATA_W   = 16,
  parameter int OUT_W    = 8,
  parameter int SHIFT_W  = 4,
  parameter int TILE_LEN = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               valid_in,
  input  logic [DATA_W-1:0]  din,
  output logic               busy,
  output logic [DATA_W-1:0]  max_abs,
  output logic [SHIFT_W-1:0] shift,
  output logic               shift_valid,
  output logic               sat
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    CALC,
    DONE
  } state_t;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(TILE_LEN - 1);
  localparam logic [DATA_W:0] LIMIT =
    (DATA_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic [SHIFT_W-1:0] S_MAX = '1;
  localparam logic [DATA_W-1:0] NEG_MIN =
    {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] POS_MAX =
    {1'b0, {(DATA_W-1){1'b1}}};

  state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic [SHIFT_W-1:0] s;
  logic [DATA_W-1:0]  abs_v;
  logic [DATA_W:0]    rnd;
  logic [DATA_W:0]    r;
  logic               fits;
  logic               take_start;
  logic               take;
  logic               finish;

  always_comb begin
    abs_v = din;
    if (din[DATA_W-1])
      abs_v = (din == NEG_MIN) ? POS_MAX : DATA_W'(-din);
  end

  // Extra top bit keeps the rounding add from wrapping.
  always_comb begin
    rnd = '0;
    if (s != '0)
      rnd = (DATA_W+1)'(1) << (s - 1'b1);
    r    = ({1'b0, max_abs} + rnd) >> s;
    fits = (r <= LIMIT);
  end

  always_comb begin
    state_nxt  = state;
    take_start = 1'b0;
    take       = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = COLLECT;
          take_start = 1'b1;
        end
      end
      COLLECT: begin
        if (valid_in) begin
          take = 1'b1;
          if (cnt == LAST)
            state_nxt = CALC;
        end
      end
      CALC: begin
        if (fits || s == S_MAX) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      s       <= '0;
      max_abs <= '0;
      shift   <= '0;
      sat     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take_start) begin
        cnt <= '0;
        s   <= '0;
`ifndef SHIFT_CALIB_TRACK_EN
        max_abs <= '0;
`endif
      end
      if (take) begin
        cnt <= cnt + 1'b1;
        if (abs_v > max_abs)
          max_abs <= abs_v;
      end
      if (state == CALC) begin
        if (finish) begin
          shift <= s;
          sat   <= ~fits;
        end else begin
          s <= s + 1'b1;
        end
      end
    end
  end

  assign busy        = (state != IDLE);
  assign shift_valid = (state == DONE);

endmodule

// File: tb/tb_shift_calib.sv
// Self-checking bench for shift_calib: vector table, scoreboard on shift_valid,
// plus hand-written abort and cross-tile sequences.
module tb_shift_calib;

  logic        clk;
  logic        rst;
  logic        start;
  logic        valid_in;
  logic [15:0] din;
  logic        busy;
  logic [15:0] max_abs;
  logic [3:0]  shift;
  logic        shift_valid;
  logic        sat;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int mx;
    int sh;
    bit st;
  } exp_t;

  typedef struct {
    logic [3:0][15:0] smp;
    int               mx;
    int               sh;
    bit               st;
    bit               gaps;
    bit               noise;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[10];

  shift_calib #(
    .DATA_W(16),
    .OUT_W(8),
    .SHIFT_W(4),
    .TILE_LEN(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .valid_in(valid_in),
    .din(din),
    .busy(busy),
    .max_abs(max_abs),
    .shift(shift),
    .shift_valid(shift_valid),
    .sat(sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [3:0][15:0] mk(
    input int a, input int b, input int c, input int d);
    logic [3:0][15:0] v;
    v[0] = 16'(a);
    v[1] = 16'(b);
    v[2] = 16'(c);
    v[3] = 16'(d);
    return v;
  endfunction

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (shift_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_shift_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("shift", int'(shift), e.sh);
        chk("sat", int'(sat), int'(e.st));
        chk("max_abs", int'(max_abs), e.mx);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_tile(
    input logic [3:0][15:0] smp, input int mx, input int sh,
    input bit st, input bit gaps, input bit noise);
    int lat;
    sb.push_back('{mx: mx, sh: sh, st: st});
    // start with a valid sample that must not be counted
    @(negedge clk);
    start    = 1'b1;
    valid_in = 1'b1;
    din      = 16'h7fff;
    @(negedge clk);
    start    = 1'b0;
    valid_in = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        valid_in = 1'b0;
        din      = 16'h7fff;
        start    = noise;
        @(negedge clk);
      end
      valid_in = 1'b1;
      din      = smp[i];
      start    = noise;
      @(negedge clk);
    end
    valid_in = 1'b1;
    din      = 16'h7fff;
    start    = noise;
    lat = -1;
    for (int k = 2; k <= 40; k++) begin
      @(posedge clk);
      #1;
      start    = 1'b0;
      valid_in = 1'b0;
      if (shift_valid) begin
        lat = k;
        break;
      end
    end
    chk("latency", lat, sh + 2);
    chk("busy_at_done", int'(busy), 1);
    @(posedge clk);
    #1;
    chk("busy_after_done", int'(busy), 0);
    chk("pulse_one_cycle", int'(shift_valid), 0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    valid_in = 1'b0;
    din      = '0;

    tbl[0] = '{mk(100, -50, 7, 0), 100, 0, 0, 0, 0};
    tbl[1] = '{mk(4080, 4080, 4080, 4080), 4080, 6, 0, 0, 0};
    tbl[2] = '{mk(-28928, -32768, 5, -1), 32767, 9, 0, 1, 0};
    tbl[3] = '{mk(-28928, 0, 0, 0), 28928, 8, 0, 0, 1};
    tbl[4] = '{mk(127, -127, 3, 0), 127, 0, 0, 1, 0};
    tbl[5] = '{mk(0, 128, -5, 2), 128, 1, 0, 0, 0};
    tbl[6] = '{mk(-128, 0, 0, 0), 128, 1, 0, 1, 1};
    tbl[7] = '{mk(0, 0, 0, 0), 0, 0, 0, 0, 0};
    tbl[8] = '{mk(255, 0, 0, 0), 255, 2, 0, 0, 1};
    tbl[9] = '{mk(0, -254, 0, 0), 254, 1, 0, 1, 0};

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_max_abs", int'(max_abs), 0);
    chk("rst_shift", int'(shift), 0);
    chk("rst_shift_valid", int'(shift_valid), 0);
    chk("rst_sat", int'(sat), 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_reset();
      run_tile(tbl[i].smp, tbl[i].mx, tbl[i].sh, tbl[i].st,
               tbl[i].gaps, tbl[i].noise);
    end

    // reset mid-COLLECT aborts the tile and clears the held shift
    do_reset();
    run_tile(mk(4080, 4080, 4080, 4080), 4080, 6, 0, 0, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    valid_in = 1'b1;
    din      = 16'd1000;
    @(negedge clk);
    din = 16'd2000;
    @(negedge clk);
    valid_in = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_shift", int'(shift), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_max_abs", int'(max_abs), 0);
    repeat (12) @(negedge clk);
    run_tile(mk(100, -50, 7, 0), 100, 0, 0, 0, 0);

    // two tiles back to back without reset
    do_reset();
    run_tile(mk(4080, 0, -4080, 1), 4080, 6, 0, 0, 0);
`ifdef SHIFT_CALIB_TRACK_EN
    run_tile(mk(100, -50, 7, 0), 4080, 6, 0, 0, 0);
`else
    run_tile(mk(100, -50, 7, 0), 100, 0, 0, 0, 0);
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
